// File: rtl/shift_ctrl_8b.sv
// shift_ctrl_8b
// Arbitrates between two requesters and drives an external parallel-load
// shift register. The winner's word is loaded with PL low, then shifted
// out MSB first on ser_out. The transfer ends with a one-cycle done/ack
// pulse to the granted requester.
//
// Ports
//   clk        rising-edge clock for all controller state
//   rst_n      asynchronous active-low reset
//   req0/req1  transfer requests, held high until the matching ack
//   data0/1    parallel words from each requester
//   D          current contents of the external shift register
//   PL         active-low parallel load strobe to the shift register
//   Din        parallel word presented to the shift register
//   gnt        one-hot grant (bit0 = requester 0, bit1 = requester 1)
//   ack0/ack1  one-cycle completion pulse to the granted requester
//   busy       high whenever the controller is not idle
//   ser_out    serial bit, MSB first
//   ser_valid  qualifies ser_out
//   done       one-cycle pulse at the end of each transfer
module shift_ctrl_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] D,
  output logic             PL,
  output logic [WIDTH-1:0] Din,
  output logic [1:0]       gnt,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_served;
  logic             pick1;

  // Only the MSB of the shift register is observed; the lower bits reach
  // it one by one as the external register shifts left.
  logic unused_d;
  assign unused_d = ^D[WIDTH-2:0];

  // Requester 1 wins when it is alone, or when both ask and requester 0
  // was the one served last.
  assign pick1 = req1 & (~req0 | ~last_served);

  // Controller FSM. All outputs are registered and change together with
  // the state so the shift register sees glitch-free controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      PL          <= 1'b1;
      Din         <= '0;
      gnt         <= 2'b00;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state       <= LOAD;
            busy        <= 1'b1;
            PL          <= 1'b0;
            gnt         <= pick1 ? 2'b10 : 2'b01;
            Din         <= pick1 ? data1 : data0;
            last_served <= pick1;
          end
        end
        LOAD: begin
          // The register captured Din on the falling edge of this cycle,
          // so its MSB is already the first serial bit.
          state     <= SHIFT;
          PL        <= 1'b1;
          ser_out   <= D[WIDTH-1];
          ser_valid <= 1'b1;
          cnt       <= '0;
        end
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            ser_valid <= 1'b0;
            done      <= 1'b1;
            ack0      <= gnt[0];
            ack1      <= gnt[1];
          end else begin
            ser_out <= D[WIDTH-1];
            cnt     <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_ctrl_8b.md
SHIFT_CTRL_8B -- requirements
Module: shift_ctrl_8b

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the controlled shift register and the number of serial bits per transfer.
REQ-002 Port: clk  input  1  single clock; all controller state SHALL update on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0  input  1  transfer request from requester 0; held high until ack0.
REQ-005 Port: data0  input  WIDTH  parallel word from requester 0; stable while req0 is high.
REQ-006 Port: req1  input  1  transfer request from requester 1; held high until ack1.
REQ-007 Port: data1  input  WIDTH  parallel word from requester 1; stable while req1 is high.
REQ-008 Port: D  input  WIDTH  output of the shift register, which loads on PL low and shifts left on the falling clk edge, with 0 entering D[0].
REQ-009 Port: PL  output  1  active-low parallel load to the shift register, registered.
REQ-010 Port: Din  output  WIDTH  parallel data to the shift register, registered.
REQ-011 Port: gnt  output  2  one-hot grant: bit0 = requester 0, bit1 = requester 1.
REQ-012 Port: ack0, ack1  output  1  one-cycle completion pulse to the granted requester.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: ser_out  output  1  serial bit, MSB first, registered.
REQ-015 Port: ser_valid  output  1  high while ser_out carries a valid bit.
REQ-016 Port: done  output  1  one-cycle pulse at the end of each transfer.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-018 IDLE: if req0 or req1 is high, the controller SHALL latch the winner into gnt, set Din to that requester's data and enter LOAD; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin with a 1-bit last-served pointer: a single requester wins outright; if both request, the one not last served wins.
REQ-020 The last-served pointer SHALL update when a grant is issued.
REQ-021 LOAD SHALL last exactly one cycle, with PL=0 for the whole cycle; PL SHALL be 1 in every other state.
REQ-022 On the LOAD->SHIFT edge: ser_out<=D[WIDTH-1], ser_valid<=1, bit counter cnt<=0.
REQ-023 SHIFT, cnt<WIDTH-1: each edge SHALL apply ser_out<=D[WIDTH-1] and cnt<=cnt+1.
REQ-024 SHIFT, cnt==WIDTH-1: the next edge SHALL enter DONE and set ser_valid<=0.
REQ-025 ser_valid SHALL be high for exactly WIDTH consecutive cycles per transfer, carrying Din[WIDTH-1] down to Din[0] in order.
REQ-026 DONE SHALL last one cycle with done=1 and ack set for the granted requester, then go to IDLE.
REQ-027 gnt SHALL clear on the DONE->IDLE edge.
REQ-028 Latency: LOAD is entered 1 cycle after req is sampled; done occurs WIDTH+2 cycles after that sample.
REQ-029 Back-to-back transfers SHALL have at least one IDLE cycle between done and the next LOAD.
REQ-030 Din and gnt SHALL stay constant from LOAD through DONE; req/data changes during a transfer SHALL be ignored.
REQ-031 If the granted req drops mid-transfer, the transfer SHALL still complete and ack SHALL still pulse.
REQ-032 cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-033 rst_n=0 SHALL immediately set: state=IDLE, PL=1, Din=0, gnt=0, ack0=ack1=0, busy=0, ser_out=0, ser_valid=0, done=0, cnt=0, last-served=1 (requester 0 wins the first tie).
REQ-034 A reset during LOAD or SHIFT SHALL abort the transfer with no ack and no done; after rst_n returns high the controller SHALL resume from IDLE.

Verification
REQ-035 Single request: req0=1, data0=8'b01100101 -> PL low for 1 cycle; ser_out=0,1,1,0,0,1,0,1 over 8 ser_valid cycles; done and ack0 pulse once, 10 cycles after req0 is sampled.
REQ-036 Tie after reset: req0=req1=1, data0=8'hA5, data1=8'h3C -> requester 0 is served first (0xA5 bits, ack0); after one IDLE cycle requester 1 is served (0x3C bits, ack1).
REQ-037 Fairness: hold req0 and req1 high for 4 transfers -> grants alternate 0,1,0,1 and neither requester is served twice in a row.
REQ-038 Mid-transfer reset: assert rst_n=0 at shift cycle 3 -> all outputs at reset values immediately; no ack or done for that transfer; a fresh request afterwards completes normally.
REQ-039 Request drop: drop req1 during SHIFT -> 8 valid bits still emitted and ack1 pulses.
REQ-040 Data change: change data0 during SHIFT -> Din and the serial stream are unchanged.
